ddr4_v2_2_20_cal_mc_odt_nt: RTL
===============================

DDR4_V2_2_20_CAL_MC_ODT_NT -- requirements
Module: ddr4_v2_2_20_cal_mc_odt_nt

Interface
REQ-001 SHALL provide these parameters (name, default, meaning):
- RANKS, 4, ranks supported, 1..8.
- RNK_BITS, 3, width of rank.
- ODTBITS, 4, ODT pins.
- WAVE_CYC, 4, fabric cycles spanned by one waveform, 2..8.
- ODTWR, 32'h8421_8421, write pin pattern, ODTBITS bits per rank, rank r at [r*ODTBITS +: ODTBITS].
- ODTWRTGT, 32'h8421_8421, write mask; 1 = pin uses target timing, 0 = non-target timing.
- ODTRD, 32'h0, read pin pattern, same layout as ODTWR.
- ODTRDTGT, 32'h0, read mask, same layout as ODTWRTGT.
- ODTWRDEL, 9, write target delay, nCK.
- ODTWRDUR, 6, write target duration, nCK.
- ODTWRODEL, 9, write non-target delay, nCK.
- ODTWRODUR, 6, write non-target duration, nCK.
- ODTRDDEL, 9, read target delay, nCK.
- ODTRDDUR, 6, read target duration, nCK.
- ODTRDODEL, 9, read non-target delay, nCK.
- ODTRDODUR, 6, read non-target duration, nCK.
- TCQ, 0.1, flop delay.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, fabric clock; single clock domain.
- rst_n, in, 1, reset; synchronous, active-low.
- casSlot, in, 2, CAS slot 0..3 within the fabric cycle.
- rank, in, RNK_BITS, CAS rank.
- winRead, in, 1, winning command is a read.
- winWrite, in, 1, winning command is a write.
- tranSentC, in, 1, CAS issued this cycle.
- cal_force_en, in, 1, calibration override enable.
- cal_force_val, in, ODTBITS, override level per pin.
- clr_coll, in, 1, clears odt_coll.
- mc_ODT, out, ODTBITS*8, 8 bits per pin; lsb = earliest.
- odt_busy, out, 1, any future waveform bit pending.
- odt_coll, out, 1, sticky overlap-conflict flag.

Function
REQ-003 SHALL run at 2 waveform bits per nCK and 8 bits per pin per fabric cycle; the waveform length is W = 8*WAVE_CYC bits.
REQ-004 SHALL set MINDEL = minimum of the four delay parameters.
REQ-005 SHALL, for each command/timing class, produce a pulse of 2*DUR ones starting at bit offset 2*(DEL-MINDEL) + 2*casSlot, measured from the first bit of the CAS cycle.
REQ-006 SHALL fail elaboration if any class satisfies 2*(DEL-MINDEL+DUR)+6 > W, if RANKS > 8, or if WAVE_CYC is outside 2..8.
REQ-007 SHALL assign pin p a new waveform only when tranSentC=1, (winRead|winWrite)=1 and pattern bit [rank*ODTBITS+p]=1; timing is target when the mask bit is 1, else non-target; winRead has priority over winWrite.
REQ-008 SHALL route bits 0..7 of the new waveform combinationally to mc_ODT in the same cycle; the remaining W-8 bits load into a per-pin shift register that advances 8 bits per cycle.
REQ-009 SHALL form mc_ODT[p*8+:8] as the OR of the new-waveform bits 0..7 and the shift-register head; overlapping waveforms OR bitwise.
REQ-010 SHALL set odt_coll on the next edge when a new read waveform overlaps any pending bit on a pin whose pending bits came from a write, or the reverse. Origin is tracked per pin per remaining cycle. Same-type overlap never sets the flag.
REQ-011 SHALL clear odt_coll on the edge where clr_coll=1 unless a collision occurs in that same cycle; set wins.
REQ-012 SHALL, while cal_force_en=1, drive mc_ODT[p*8+:8] = {8{cal_force_val[p]}} combinationally.
REQ-013 SHALL keep the shift register advancing during force, ignore new CAS during force, and resume normal output on the first cycle cal_force_en=0.
REQ-014 SHALL drive odt_busy combinationally as the OR of all shift-register bits.
REQ-015 SHALL treat rank >= RANKS as no-ODT: no pins assert and odt_coll is unaffected.

Reset
REQ-016 SHALL, on the rising clk edge with rst_n=0, clear all shift registers, origin tags and odt_coll.
REQ-017 SHALL, during reset, drive mc_ODT=0 (unless cal_force_en=1) and odt_busy=0, and ignore tranSentC.
REQ-018 SHALL discard any in-flight waveform when reset is applied mid-operation; no residual bits appear after rst_n returns to 1.

Verification
REQ-019 Default write to rank 0, slot 0, tranSentC=1 -> pin0 mc_ODT cycle0 = 8'hFF, cycle1 = 8'h0F, then 0; odt_busy=1 for exactly one cycle.
REQ-020 Same write at casSlot=2 -> pin0 cycle0 = 8'hF0, cycle1 = 8'hFF; pins 1..3 = 0 throughout.
REQ-021 With ODTRD=32'h000E and ODTRDODEL=11, read to rank 0 then write to rank 1 one cycle later -> pin1 waveforms OR together; odt_coll=1 from the following cycle until clr_coll.
REQ-022 Write CAS at cycle 0, rst_n=0 at cycle 1 -> mc_ODT=0 from cycle 1 onward; odt_busy=0 after the reset edge.
REQ-023 cal_force_en=1 with cal_force_val=4'b1010 during a pending write -> mc_ODT = 32'hFF00_FF00; after release only the remaining un-shifted bits appear.
REQ-024 rank=5 with RANKS=4 plus a write CAS -> mc_ODT stays 0 and odt_busy stays 0.

Source files
------------

// File: rtl/ddr4_v2_2_20_cal_mc_odt_nt_if.sv
// CAS/ODT bundle between the MC command path and the ODT waveform generator.
// Fabric side drives CAS and override controls; the generator returns pin waveforms.
interface ddr4_v2_2_20_cal_mc_odt_nt_if #(
  parameter int RNK_BITS = 3,
  parameter int ODTBITS  = 4
);
  logic [1:0]           casSlot;
  logic [RNK_BITS-1:0]  rank;
  logic                 winRead;
  logic                 winWrite;
  logic                 tranSentC;
  logic                 cal_force_en;
  logic [ODTBITS-1:0]   cal_force_val;
  logic                 clr_coll;
  logic [ODTBITS*8-1:0] mc_ODT;
  logic                 odt_busy;
  logic                 odt_coll;

  modport master (
    output casSlot, rank, winRead, winWrite, tranSentC,
    output cal_force_en, cal_force_val, clr_coll,
    input  mc_ODT, odt_busy, odt_coll
  );

  modport slave (
    input  casSlot, rank, winRead, winWrite, tranSentC,
    input  cal_force_en, cal_force_val, clr_coll,
    output mc_ODT, odt_busy, odt_coll
  );
endinterface

// File: rtl/ddr4_v2_2_20_cal_mc_odt_nt.sv
// ODT waveform generator: per-pin 2-bit/nCK pulses from CAS, shifted out 8 bits/cycle.
// Tracks read/write origin per pending cycle to flag conflicting overlaps.
module ddr4_v2_2_20_cal_mc_odt_nt #(
  parameter int  RANKS     = 4,
  parameter int  RNK_BITS  = 3,
  parameter int  ODTBITS   = 4,
  parameter int  WAVE_CYC  = 4,
  parameter logic [8*ODTBITS-1:0] ODTWR    = 32'h8421_8421,
  parameter logic [8*ODTBITS-1:0] ODTWRTGT = 32'h8421_8421,
  parameter logic [8*ODTBITS-1:0] ODTRD    = 32'h0,
  parameter logic [8*ODTBITS-1:0] ODTRDTGT = 32'h0,
  parameter int  ODTWRDEL  = 9,
  parameter int  ODTWRDUR  = 6,
  parameter int  ODTWRODEL = 9,
  parameter int  ODTWRODUR = 6,
  parameter int  ODTRDDEL  = 9,
  parameter int  ODTRDDUR  = 6,
  parameter int  ODTRDODEL = 9,
  parameter int  ODTRDODUR = 6,
  parameter real TCQ       = 0.1
) (
  input logic clk,
  input logic rst_n,
  ddr4_v2_2_20_cal_mc_odt_nt_if.slave bus
);

  localparam int W   = 8 * WAVE_CYC;
  localparam int SRW = W - 8;
  localparam int NC  = WAVE_CYC - 1;
  localparam int IW  = $clog2(8 * ODTBITS);

  function automatic int min4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  localparam int MINDEL = min4(ODTWRDEL, ODTWRODEL, ODTRDDEL, ODTRDODEL);

  function automatic logic [W-1:0] pulse(input int del, input int dur);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++)
      m[i] = (i >= 2*(del-MINDEL)) && (i < 2*(del-MINDEL+dur));
    return m;
  endfunction

  localparam logic [W-1:0] P_WRT = pulse(ODTWRDEL,  ODTWRDUR);
  localparam logic [W-1:0] P_WRO = pulse(ODTWRODEL, ODTWRODUR);
  localparam logic [W-1:0] P_RDT = pulse(ODTRDDEL,  ODTRDDUR);
  localparam logic [W-1:0] P_RDO = pulse(ODTRDODEL, ODTRDODUR);

  // Slot shift of up to 6 bits must never push a pulse past the window.
  localparam bit BAD_CFG =
    (2*(ODTWRDEL-MINDEL+ODTWRDUR)+6 > W) ||
    (2*(ODTWRODEL-MINDEL+ODTWRODUR)+6 > W) ||
    (2*(ODTRDDEL-MINDEL+ODTRDDUR)+6 > W) ||
    (2*(ODTRDODEL-MINDEL+ODTRDODUR)+6 > W) ||
    (RANKS > 8) || (RANKS < 1) ||
    (WAVE_CYC < 2) || (WAVE_CYC > 8);

  generate
    if (BAD_CFG) begin : g_bad_cfg
      $error("ddr4_v2_2_20_cal_mc_odt_nt: illegal ODT timing configuration");
    end
  endgenerate

  logic [ODTBITS-1:0][SRW-1:0] r_sr;
  logic [ODTBITS-1:0][NC-1:0]  r_rtag;
  logic [ODTBITS-1:0][NC-1:0]  r_wtag;
  logic                        r_coll;

  logic [ODTBITS-1:0][W-1:0]   w_new;
  logic [ODTBITS-1:0][SRW-1:0] w_sr_nxt;
  logic [ODTBITS-1:0][NC-1:0]  w_rtag_nxt;
  logic [ODTBITS-1:0][NC-1:0]  w_wtag_nxt;
  logic                        w_cas;
  logic                        w_rd;
  logic                        w_sel;
  logic                        w_tgt;
  logic                        w_coll;
  logic [2:0]                  w_sh;
  logic [IW-1:0]               w_idx;
  logic [W-1:0]                w_msk;

  always_comb begin
    w_cas = rst_n & ~bus.cal_force_en & bus.tranSentC &
            (bus.winRead | bus.winWrite) & (int'(bus.rank) < RANKS);
    w_rd  = bus.winRead;
    w_sh  = {bus.casSlot, 1'b0};
    w_coll     = 1'b0;
    w_new      = '0;
    w_sr_nxt   = '0;
    w_rtag_nxt = '0;
    w_wtag_nxt = '0;
    w_idx = '0;
    w_sel = 1'b0;
    w_tgt = 1'b0;
    w_msk = '0;
    for (int p = 0; p < ODTBITS; p++) begin
      w_idx = IW'(int'(bus.rank) * ODTBITS + p);
      w_sel = w_rd ? ODTRD[w_idx]    : ODTWR[w_idx];
      w_tgt = w_rd ? ODTRDTGT[w_idx] : ODTWRTGT[w_idx];
      w_msk = w_rd ? (w_tgt ? P_RDT : P_RDO)
                   : (w_tgt ? P_WRT : P_WRO);
      if (w_cas && w_sel)
        w_new[p] = w_msk << w_sh;
      w_sr_nxt[p]   = (r_sr[p] >> 8) | w_new[p][W-1:8];
      w_rtag_nxt[p] = r_rtag[p] >> 1;
      w_wtag_nxt[p] = r_wtag[p] >> 1;
      for (int c = 0; c < NC; c++) begin
        if ((|(w_new[p][c*8 +: 8] & r_sr[p][c*8 +: 8])) &&
            (w_rd ? r_wtag[p][c] : r_rtag[p][c]))
          w_coll = 1'b1;
        if (|w_new[p][(c+1)*8 +: 8]) begin
          if (w_rd) w_rtag_nxt[p][c] = 1'b1;
          else      w_wtag_nxt[p][c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.mc_ODT = '0;
    for (int p = 0; p < ODTBITS; p++) begin
      if (bus.cal_force_en)
        bus.mc_ODT[p*8 +: 8] = {8{bus.cal_force_val[p]}};
      else if (rst_n)
        bus.mc_ODT[p*8 +: 8] = w_new[p][7:0] | r_sr[p][7:0];
    end
    bus.odt_busy = rst_n & (|r_sr);
    bus.odt_coll = r_coll;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_rtag <= '0;
      r_wtag <= '0;
      r_coll <= 1'b0;
    end else begin
      r_sr   <= w_sr_nxt;
      r_rtag <= w_rtag_nxt;
      r_wtag <= w_wtag_nxt;
      if (w_coll)
        r_coll <= 1'b1;
      else if (bus.clr_coll)
        r_coll <= 1'b0;
    end
  end

endmodule
